// File: rtl/mem_stage.sv
// MEM stage of the MIPS pipeline: req/ack data-memory access with timeout,
// branch/jump redirect and the MEM/WB pipeline register.
module mem_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] PC_next_MEM,
  input  logic [DATA_W-1:0] resultadoALU_MEM,
  input  logic [DATA_W-1:0] Read_Data_2_MEM,
  input  logic              Branch_MEM,
  input  logic              MemRead_MEM,
  input  logic              MemToReg_MEM,
  input  logic              MemWrite_MEM,
  input  logic              RegWrite_MEM,
  input  logic              Jump_MEM,
  input  logic              Zero_MEM,
  input  logic [REG_W-1:0]  Write_register_MEM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic              PCSrc,
  output logic [DATA_W-1:0] PC_target,
  output logic [DATA_W-1:0] Read_Data_WB,
  output logic [DATA_W-1:0] resultadoALU_WB,
  output logic              MemToReg_WB,
  output logic              RegWrite_WB,
  output logic [REG_W-1:0]  Write_register_WB,
  output logic              err
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             memop;
  logic             illegal;
  logic             legal;
  logic             timeout_hit;

  assign memop   = MemRead_MEM | MemWrite_MEM;
  assign illegal = (MemRead_MEM & MemWrite_MEM) |
                   (memop & (resultadoALU_MEM[1:0] != 2'b00));
  assign legal   = memop & ~illegal;

  // An ack landing in the timeout cycle still wins.
  assign timeout_hit = (state == WAIT) && (cnt == CNT_W'(TIMEOUT)) && !mem_ack;

  assign mem_req   = legal & ~timeout_hit & ~reset;
  assign mem_we    = MemWrite_MEM;
  assign mem_addr  = resultadoALU_MEM;
  assign mem_wdata = Read_Data_2_MEM;

  assign stall     = legal & ~mem_ack & ~timeout_hit;
  assign PCSrc     = ((Branch_MEM & Zero_MEM) | Jump_MEM) & ~stall;
  assign PC_target = PC_next_MEM;
  assign err       = (illegal | timeout_hit) & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (state == IDLE) begin
      if (legal && !mem_ack) begin
        state <= WAIT;
        cnt   <= CNT_W'(1);
      end
    end else begin
      if (mem_ack || timeout_hit) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Dropped or still-waiting instructions leave a bubble; data fields hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      Read_Data_WB      <= '0;
      resultadoALU_WB   <= '0;
      MemToReg_WB       <= 1'b0;
      RegWrite_WB       <= 1'b0;
      Write_register_WB <= '0;
    end else if (illegal || timeout_hit || stall) begin
      MemToReg_WB <= 1'b0;
      RegWrite_WB <= 1'b0;
    end else begin
      resultadoALU_WB   <= resultadoALU_MEM;
      Write_register_WB <= Write_register_MEM;
      MemToReg_WB       <= MemToReg_MEM;
      RegWrite_WB       <= RegWrite_MEM;
      if (MemRead_MEM && legal) begin
        Read_Data_WB <= mem_rdata;
      end
    end
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Consumer end of the EX/MEM pipeline register in the MIPS pipeline.
- Takes the registered EX/MEM control and data signals and performs load/store accesses on a req/ack data-memory bus.
- Resolves branch and jump redirection (PCSrc).
- Drives the registered MEM/WB outputs and a stall to freeze the upstream stages while a memory access is outstanding.

Parameters:
DATA_W, 32, data/address width
REG_W, 5, destination register index width
TIMEOUT, 16, max cycles in WAIT before bus error (>=1)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
PC_next_MEM  in  DATA_W  branch/jump target from EX/MEM
resultadoALU_MEM  in  DATA_W  ALU result / memory address
Read_Data_2_MEM  in  DATA_W  store data
Branch_MEM, MemRead_MEM, MemToReg_MEM, MemWrite_MEM, RegWrite_MEM, Jump_MEM, Zero_MEM  in  1 each  EX/MEM control
Write_register_MEM  in  REG_W  destination register
mem_req  out  1  memory request, held until ack
mem_we  out  1  1=store, 0=load
mem_addr  out  DATA_W  = resultadoALU_MEM
mem_wdata  out  DATA_W  = Read_Data_2_MEM
mem_rdata  in  DATA_W  load data, valid when mem_ack=1
mem_ack  in  1  single-cycle completion
stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM this cycle
PCSrc  out  1  select PC_target
PC_target  out  DATA_W  = PC_next_MEM
Read_Data_WB  out  DATA_W  registered load data
resultadoALU_WB  out  DATA_W  registered ALU result
MemToReg_WB, RegWrite_WB  out  1  registered control
Write_register_WB  out  REG_W  registered destination
err  out  1  one-cycle pulse: misaligned, illegal or timed-out access

Behaviour:
- Decode:
  - memop = MemRead_MEM | MemWrite_MEM.
  - illegal = MemRead_MEM & MemWrite_MEM, or memop with resultadoALU_MEM[1:0] != 0.
  - legal = memop & !illegal.
- mem_req = legal & !timeout_hit (combinational, both states); mem_we = MemWrite_MEM; addr/wdata pass-through; addr/wdata/we held stable because EX/MEM is frozen by stall.
- stall = legal & !mem_ack & !timeout_hit.
- Zero-wait memory: ack in the first cycle completes with no stall.
- PCSrc = (Branch_MEM & Zero_MEM) | Jump_MEM, combinational.
  - PCSrc is forced 0 while stall=1 so the redirect is taken exactly once, in the completing cycle.
- FSM, states IDLE and WAIT:
  - IDLE -> WAIT when legal & !mem_ack; cnt <= 1.
  - WAIT, each cycle without ack: cnt++.
  - timeout_hit = (state==WAIT && cnt==TIMEOUT).
  - WAIT -> IDLE on mem_ack or timeout_hit.
  - In IDLE, legal & mem_ack completes with no state change.
- MEM/WB register, updated on every rising edge:
  - Stall cycle: bubble. RegWrite_WB=0, MemToReg_WB=0, others hold.
  - Completing cycle (non-memop, or legal & mem_ack): load resultadoALU_WB, Write_register_WB, MemToReg_WB, RegWrite_WB from inputs. Read_Data_WB <= mem_rdata for a load; it holds otherwise.
  - illegal or timeout_hit cycle: bubble with RegWrite_WB=0, err pulses 1 for that cycle, no memory access beyond the timed-out one, and stall=0 so the pipeline advances (instruction dropped).
- Simultaneous events:
  - mem_ack arriving in the same cycle as timeout_hit counts as success; timeout_hit is gated by !mem_ack.
  - A late ack arriving in IDLE with no legal op is ignored.
- Reset (synchronous, overrides everything including mid-WAIT):
  - state=IDLE, cnt=0.
  - All _WB outputs 0, err=0.
  - Combinational outputs follow inputs; mem_req is 0 during reset regardless.
  - An access aborted by reset is not retried.

Test Plan:
- ALU op (RegWrite=1, addr=0x10, Write_register=5, no memop) -> next edge RegWrite_WB=1, resultadoALU_WB=0x10, Write_register_WB=5; stall never 1.
- Load addr=0x100, ack after 3 wait cycles with rdata=0xDEADBEEF -> mem_req high 4 cycles, stall high 3, RegWrite_WB=0 during stall; completion edge gives Read_Data_WB=0xDEADBEEF, MemToReg_WB=1.
- Store addr=0x44 wdata=0x12345678 with same-cycle ack -> single cycle, mem_we=1, stall=0, RegWrite_WB=0.
- Load addr=0x102 (misaligned), or MemRead=MemWrite=1 -> mem_req=0, err pulse 1 cycle, RegWrite_WB=0, stall=0.
- Load with no ack, TIMEOUT=16 -> stall high 16 cycles, err pulse on the 17th, FSM back to IDLE; a later stray ack has no effect.
- Branch=1, Zero=1 behind a 2-cycle-wait load -> PCSrc=0 while stalled, 1 only in the ack cycle, PC_target=PC_next_MEM. Reset asserted mid-WAIT -> next edge IDLE, all _WB=0, mem_req=0.
